// File: rtl/shift_serializer.sv
// shift_serializer: parallel-load shift register that emits STEP bits per beat,
// with logical/rotate/arithmetic/serial-fill modes and a load/done handshake.
module shift_serializer #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [STEP-1:0]  ser_in,
    input  logic             en_shift,
    output logic [WIDTH-1:0] data_out,
    output logic [STEP-1:0]  ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);
    localparam int BEATS = WIDTH / STEP;
    localparam int CW = $clog2(BEATS + 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode_q, mode_d;
    logic [STEP-1:0]  ser_q, ser_d, out_bits, fill;
    logic             sv_q, done_q, load, beat, last;

    assign load     = load_valid && state_q == IDLE;
    // the cnt_q guard keeps the counter from ever wrapping below zero
    assign beat     = state_q == SHIFT && en_shift && cnt_q != '0;
    assign last     = beat && cnt_q == CW'(1);
    assign out_bits = dir_q ? data_q[STEP-1:0] : data_q[WIDTH-1 -: STEP];

    always_comb begin
        fill    = mode_q == 2'b01 ? out_bits :
                  mode_q == 2'b11 ? ser_in :
                  (mode_q == 2'b10 && dir_q) ? {STEP{data_q[WIDTH-1]}} : '0;
        shifted = dir_q ? {fill, data_q[WIDTH-1:STEP]} : {data_q[WIDTH-STEP-1:0], fill};
        state_d = load ? SHIFT : last ? IDLE : state_q;
        data_d  = load ? data_in : beat ? shifted : data_q;
        cnt_d   = load ? CW'(BEATS) : beat ? cnt_q - CW'(1) : cnt_q;
        dir_d   = load ? dir : dir_q;
        mode_d  = load ? mode : mode_q;
        ser_d   = beat ? out_bits : ser_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            ser_q   <= '0;
            sv_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            ser_q   <= ser_d;
            sv_q    <= beat;
            done_q  <= last;
        end
    end

    assign load_ready = state_q == IDLE;
    assign busy       = state_q == SHIFT;
    assign data_out   = data_q;
    assign ser_out    = ser_q;
    assign ser_valid  = sv_q;
    assign done       = done_q;
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: drives a STEP=1 and a STEP=2 instance with shared stimulus and
// checks every cycle against a per-instance arithmetic reference model via scoreboards.
module tb_shift_serializer;
    typedef struct {
        logic       sv;
        logic [1:0] so;
        logic [7:0] d;
        logic       busy;
        logic       done;
        logic       rdy;
    } rec_t;

    logic       clk = 1'b0, rst = 1'b1, load_valid = 1'b0, dir = 1'b0, en_shift = 1'b0;
    logic [1:0] mode = 2'b00, ser_in = 2'b00;
    logic [7:0] data_in = 8'h00;

    logic [7:0] dout1, dout2;
    logic       sout1;
    logic [1:0] sout2;
    logic       rdy1, rdy2, sv1, sv2, busy1, busy2, done1, done2;

    rec_t sb0[$], sb1[$];
    int   m_d[2], m_so[2], m_cnt[2], m_mode[2];
    logic m_dir[2];
    int   n_chk = 0, n_fail = 0;
    logic [7:0] got;

    always #5 clk = ~clk;

    shift_serializer #(.WIDTH(8), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy1), .data_in(data_in),
        .dir(dir), .mode(mode), .ser_in(ser_in[0]), .en_shift(en_shift), .data_out(dout1),
        .ser_out(sout1), .ser_valid(sv1), .busy(busy1), .done(done1)
    );

    shift_serializer #(.WIDTH(8), .STEP(2)) u2 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy2), .data_in(data_in),
        .dir(dir), .mode(mode), .ser_in(ser_in), .en_shift(en_shift), .data_out(dout2),
        .ser_out(sout2), .ser_valid(sv2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One beat on an 8-bit word, expressed as integer shifts and masks.
    task automatic beat(input int d, input logic r, input int md, input int si, input int s,
                        output int o, output int nd);
        int m;
        m = (1 << s) - 1;
        if (r) begin
            o  = d & m;
            nd = d >> s;
            if (md == 1) nd = nd | (o << (8 - s));
            if (md == 2 && d >= 128) nd = nd | (m << (8 - s));
            if (md == 3) nd = nd | ((si & m) << (8 - s));
        end else begin
            o  = d >> (8 - s);
            nd = (d << s) & 255;
            if (md == 1) nd = nd | o;
            if (md == 3) nd = nd | (si & m);
        end
    endtask

    task automatic tick(input int k);
        int   s, o, nd;
        rec_t r;
        s = k + 1;
        r.sv = 1'b0;
        r.done = 1'b0;
        if (rst) begin
            m_d[k] = 0; m_so[k] = 0; m_cnt[k] = 0;
        end else if (m_cnt[k] == 0) begin
            if (load_valid) begin
                m_d[k] = int'(data_in); m_dir[k] = dir; m_mode[k] = int'(mode); m_cnt[k] = 8 / s;
            end
        end else if (en_shift) begin
            beat(m_d[k], m_dir[k], m_mode[k], int'(ser_in), s, o, nd);
            m_d[k] = nd; m_so[k] = o; m_cnt[k]--;
            r.sv = 1'b1;
            r.done = m_cnt[k] == 0;
        end
        r.d    = 8'(m_d[k]);
        r.so   = 2'(m_so[k]);
        r.busy = m_cnt[k] != 0;
        r.rdy  = m_cnt[k] == 0;
        if (k == 0) sb0.push_back(r);
        else sb1.push_back(r);
    endtask

    task automatic cyc();
        tick(0);
        tick(1);
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d, input logic r, input logic [1:0] md);
        load_valid = 1'b1; data_in = d; dir = r; mode = md;
        cyc();
        load_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb0.size() != 0) begin
            rec_t r;
            r = sb0.pop_front();
            chk("u1_ser_valid", int'(sv1), int'(r.sv));
            chk("u1_ser_out", int'(sout1), int'(r.so[0]));
            chk("u1_data_out", int'(dout1), int'(r.d));
            chk("u1_busy", int'(busy1), int'(r.busy));
            chk("u1_done", int'(done1), int'(r.done));
            chk("u1_load_ready", int'(rdy1), int'(r.rdy));
        end
        if (sb1.size() != 0) begin
            rec_t r;
            r = sb1.pop_front();
            chk("u2_ser_valid", int'(sv2), int'(r.sv));
            chk("u2_ser_out", int'(sout2), int'(r.so));
            chk("u2_data_out", int'(dout2), int'(r.d));
            chk("u2_busy", int'(busy2), int'(r.busy));
            chk("u2_done", int'(done2), int'(r.done));
            chk("u2_load_ready", int'(rdy2), int'(r.rdy));
        end
    end

    initial begin
        logic [7:0] exp35[4];
        exp35[0] = 8'h03; exp35[1] = 8'h0F; exp35[2] = 8'h3F; exp35[3] = 8'hFF;
        cyc();
        cyc();
        rst = 1'b0;
        en_shift = 1'b1;
        // 0xA5 logical right: LSB-first bit stream, register empties, done follows
        load(8'hA5, 1'b1, 2'b00);
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cyc();
            got = {got[6:0], sout1};
        end
        chk("a5_bits", int'(got), 'hA5);
        chk("a5_data", int'(dout1), 0);
        chk("a5_done", int'(done1), 1);
        // rotate left, loaded in the done cycle
        load(8'h81, 1'b0, 2'b01);
        cyc();
        chk("rot_beat1", int'(dout1), 'h03);
        repeat (7) cyc();
        chk("rot_beat8", int'(dout1), 'h81);
        chk("rot_done", int'(done1), 1);
        load(8'h80, 1'b1, 2'b10);
        repeat (3) cyc();
        chk("arith_beat3", int'(dout1), 'hF0);
        repeat (5) cyc();
        chk("arith_beat8", int'(dout1), 'hFF);
        // stall for two cycles after beat 3
        load(8'h5A, 1'b1, 2'b00);
        repeat (3) cyc();
        en_shift = 1'b0;
        repeat (2) cyc();
        chk("stall_busy", int'(busy1), 1);
        chk("stall_valid", int'(sv1), 0);
        en_shift = 1'b1;
        repeat (4) cyc();
        chk("stall_not_done_early", int'(done1), 0);
        cyc();
        chk("stall_done", int'(done1), 1);
        // reset mid-word while a second load is being offered
        load(8'hC3, 1'b0, 2'b00);
        load_valid = 1'b1; data_in = 8'hFF; dir = 1'b1; mode = 2'b01;
        repeat (4) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_data", int'(dout1), 0);
        chk("rst_ready", int'(rdy1), 1);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        rst = 1'b0;
        data_in = 8'h3C;
        cyc();
        load_valid = 1'b0;
        chk("post_rst_load", int'(dout1), 'h3C);
        repeat (10) cyc();
        // STEP=2 serial fill, then a second word loaded in its done cycle
        ser_in = 2'b11;
        load(8'h00, 1'b0, 2'b11);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("fill2_data", int'(dout2), int'(exp35[i]));
        end
        chk("fill2_done", int'(done2), 1);
        load(8'h96, 1'b1, 2'b00);
        chk("fill2_reload", int'(dout2), 'h96);
        for (int i = 0; i < 400; i++) begin
            rst        = $urandom_range(0, 63) == 0;
            load_valid = 1'($urandom);
            data_in    = 8'($urandom);
            dir        = 1'($urandom);
            mode       = 2'($urandom);
            en_shift   = $urandom_range(0, 3) != 0;
            ser_in     = 2'($urandom);
            cyc();
        end
        rst = 1'b0;
        load_valid = 1'b0;
        en_shift = 1'b1;
        repeat (10) cyc();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb0.size() + sb1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
